// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } loader_state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int COUNT_W    = 16;

  // States in which the loader is willing to take bytes from the link.
  function automatic logic is_loading(loader_state_e s);
    return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words. word_valid_o fires
// combinationally on the byte that completes a word, with word_o carrying
// the finished word in that same cycle.
module word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;

  // First byte ends up in bits 7:0 after four right-shifts.
  assign word_o       = {byte_i, sh_q[31:8]};
  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'(WORD_BYTES - 1));

  // Byte counter and shift register next-state.
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clear_i) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = word_o;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives [N lo, N hi, N*4 payload bytes, XOR checksum] over a
// byte link, writes the words into instruction memory and releases the core
// from reset only once the checksum matches.
//
// Byte handshake: a byte moves on a rising clk edge where rx_valid && rx_ready
// are both high; rx_valid is ignored while rx_ready is low, and a reload_req
// in the same cycle wins so that byte is not consumed.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int          IMEM_DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  input  logic               reload_req,
  output logic               imem_we,
  output logic [31:0]        imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               core_resetn,
  output logic               load_done,
  output logic               load_error,
  output logic [COUNT_W-1:0] words_loaded,
  output logic [2:0]         dbg_state
);

  localparam int HDR_W = 8 * HDR_BYTES;

  loader_state_e      state_q, state_d;
  logic [HDR_W-1:0]   count_q, count_d;
  logic [7:0]         csum_q, csum_d;
  logic [31:0]        idle_q, idle_d;
  logic               rx_ready_q, rx_ready_d;
  logic               we_q, we_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               core_resetn_q, core_resetn_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [COUNT_W-1:0] words_q, words_d;

  logic               take;
  logic [HDR_W-1:0]   hdr_count;
  logic               timeout_hit;
  logic               last_word;
  logic               word_valid;
  logic [31:0]        word;

  assign take        = rx_valid && rx_ready_q && !reload_req;
  assign hdr_count   = {rx_data, count_q[HDR_W-1:8]};
  assign timeout_hit = !take && (idle_q == 32'(TIMEOUT_CYCLES - 1));
  assign last_word   = (COUNT_W'(words_q + 1'b1) == count_q);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (reload_req || (state_q == HDR1)),
    .byte_valid_i (take && (state_q == DATA)),
    .byte_i       (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // FSM next state; reload_req overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR0: if (take) state_d = HDR1;
      HDR1: begin
        if (take) begin
          if (hdr_count == '0)                        state_d = CSUM;
          else if (32'(hdr_count) > 32'(IMEM_DEPTH))  state_d = ERR;
          else                                        state_d = DATA;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DATA: begin
        if (word_valid && last_word) state_d = CSUM;
        else if (timeout_hit)        state_d = ERR;
      end
      CSUM: begin
        if (take)             state_d = (rx_data == csum_q) ? RUN : ERR;
        else if (timeout_hit) state_d = ERR;
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
    if (reload_req) state_d = HDR0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= HDR0;
    else       state_q <= state_d;
  end

  // Datapath and registered-output next values.
  always_comb begin
    count_d       = count_q;
    csum_d        = csum_q;
    idle_d        = '0;
    wdata_d       = wdata_q;
    waddr_d       = waddr_q;
    words_d       = words_q;
    we_d          = word_valid;
    rx_ready_d    = is_loading(state_d);
    done_d        = (state_d == RUN);
    error_d       = !reload_req && (error_q || (state_d == ERR));
    core_resetn_d = (state_q == RUN) && !reload_req;

    if (take && (state_q == HDR0 || state_q == HDR1)) count_d = hdr_count;
    if (state_q == HDR1)                              csum_d  = '0;
    else if (take && state_q == DATA)                 csum_d  = csum_q ^ rx_data;

    if ((state_q == HDR1 || state_q == DATA || state_q == CSUM) && !take && !reload_req)
      idle_d = idle_q + 32'd1;

    if (word_valid) begin
      wdata_d = word;
      waddr_d = BASE_ADDR + {{(32 - COUNT_W - 2){1'b0}}, words_q, 2'b00};
      words_d = words_q + 1'b1;
    end
    if (reload_req) words_d = '0;
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      csum_q        <= '0;
      idle_q        <= '0;
      rx_ready_q    <= 1'b0;
      we_q          <= 1'b0;
      waddr_q       <= BASE_ADDR;
      wdata_q       <= '0;
      core_resetn_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      words_q       <= '0;
    end else begin
      count_q       <= count_d;
      csum_q        <= csum_d;
      idle_q        <= idle_d;
      rx_ready_q    <= rx_ready_d;
      we_q          <= we_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      core_resetn_q <= core_resetn_d;
      done_q        <= done_d;
      error_q       <= error_d;
      words_q       <= words_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_resetn  = core_resetn_q;
  assign load_done    = done_q;
  assign load_error   = error_q;
  assign words_loaded = words_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: byte-stream driver, write-port scoreboard,
// directed checks on handshake, checksum, timeout, reload and reset.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          TMO   = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        reload_req = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_resetn;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [79:0] exp_q[$];          // {words_loaded, addr, data}
  logic [79:0] mon_e;
  logic [31:0] img[16];

  imem_boot_loader #(
    .IMEM_DEPTH     (DEPTH),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .reload_req   (reload_req),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_resetn  (core_resetn),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", 64'(imem_waddr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr",  64'(imem_waddr),   64'(mon_e[63:32]));
        check("we_data",  64'(imem_wdata),   64'(mon_e[31:0]));
        check("we_count", 64'(words_loaded), 64'(mon_e[79:64]));
      end
    end
  end

  // Drivers: all start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = rx_ready;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_ready_wait", 64'(0), 64'(1));
  endtask

  task automatic send_image(input int n, input int gap_max, input logic [7:0] csum_flip);
    logic [7:0] cs;
    logic [7:0] b;
    logic [15:0] n16;
    n16 = 16'(n);
    cs  = 8'h00;
    send_byte(n16[7:0],  $urandom_range(0, gap_max));
    send_byte(n16[15:8], $urandom_range(0, gap_max));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({16'(i + 1), BASE + 32'(4 * i), img[i]});
      for (int j = 0; j < 4; j++) begin
        b  = img[i][8*j +: 8];
        cs = cs ^ b;
        send_byte(b, $urandom_range(0, gap_max));
      end
    end
    send_byte(cs ^ csum_flip, $urandom_range(0, gap_max));
  endtask

  task automatic pulse_reload();
    reload_req = 1'b1;
    @(negedge clk);
    reload_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"},    64'(rx_ready),     64'(0));
    check({tag, "_we"},          64'(imem_we),      64'(0));
    check({tag, "_waddr"},       64'(imem_waddr),   64'(BASE));
    check({tag, "_wdata"},       64'(imem_wdata),   64'(0));
    check({tag, "_core_resetn"}, 64'(core_resetn),  64'(0));
    check({tag, "_done"},        64'(load_done),    64'(0));
    check({tag, "_error"},       64'(load_error),   64'(0));
    check({tag, "_words"},       64'(words_loaded), 64'(0));
    check({tag, "_state"},       64'(dbg_state),    64'(HDR0));
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    check("rst_ready_low_at_release", 64'(rx_ready), 64'(0));
    @(negedge clk);
    check("rst_ready_rises", 64'(rx_ready), 64'(1));

    // Two-word image, good checksum
    img[0] = 32'h0050_0093;
    img[1] = 32'h00A0_0113;
    send_image(2, 0, 8'h00);
    check("ok_done",        64'(load_done),    64'(1));
    check("ok_words",       64'(words_loaded), 64'(2));
    check("ok_ready_low",   64'(rx_ready),     64'(0));
    check("ok_resetn_held", 64'(core_resetn),  64'(0));
    check("ok_queue_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("ok_resetn_rise", 64'(core_resetn),  64'(1));

    // Same image, bad checksum
    pulse_reload();
    check("rl_resetn_drop", 64'(core_resetn), 64'(0));
    check("rl_done_clear",  64'(load_done),   64'(0));
    send_image(2, 0, 8'h01);
    check("bad_error",    64'(load_error), 64'(1));
    check("bad_ready",    64'(rx_ready),   64'(0));
    check("bad_state",    64'(dbg_state),  64'(ERR));
    repeat (5) @(negedge clk);
    check("bad_resetn",   64'(core_resetn), 64'(0));
    pulse_reload();
    check("bad_rl_ready", 64'(rx_ready),   64'(1));
    check("bad_rl_error", 64'(load_error), 64'(0));
    check("bad_rl_state", 64'(dbg_state),  64'(HDR0));
    check("bad_rl_words", 64'(words_loaded), 64'(0));

    // Empty image
    send_image(0, 2, 8'h00);
    check("n0_done",  64'(load_done),    64'(1));
    check("n0_words", 64'(words_loaded), 64'(0));

    // Oversized header
    pulse_reload();
    send_byte(8'(DEPTH + 1), 0);
    send_byte(8'((DEPTH + 1) >> 8), 0);
    check("big_error", 64'(load_error), 64'(1));
    check("big_state", 64'(dbg_state),  64'(ERR));
    check("big_ready", 64'(rx_ready),   64'(0));

    // Eight random words with random gaps up to TMO-1
    pulse_reload();
    for (int i = 0; i < 8; i++) img[i] = $urandom;
    send_image(8, TMO - 1, 8'h00);
    check("rnd_done",  64'(load_done),    64'(1));
    check("rnd_error", 64'(load_error),   64'(0));
    check("rnd_words", 64'(words_loaded), 64'(8));
    check("rnd_queue", 64'(exp_q.size()), 64'(0));

    // Timeout boundary in DATA
    pulse_reload();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, TMO - 1);
    check("tmo_gap_ok", 64'(load_error), 64'(0));
    repeat (TMO - 1) @(negedge clk);
    check("tmo_before", 64'(load_error), 64'(0));
    @(negedge clk);
    check("tmo_error",  64'(load_error), 64'(1));
    check("tmo_state",  64'(dbg_state),  64'(ERR));

    // Reload colliding with a byte mid-DATA
    pulse_reload();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rx_valid   = 1'b1;
    rx_data    = 8'h05;
    reload_req = 1'b1;
    @(negedge clk);
    rx_valid   = 1'b0;
    reload_req = 1'b0;
    check("col_state",  64'(dbg_state),    64'(HDR0));
    check("col_words",  64'(words_loaded), 64'(0));
    check("col_resetn", 64'(core_resetn),  64'(0));
    img[0] = 32'h1234_5678;
    send_image(1, 3, 8'h00);
    check("col_done",   64'(load_done),    64'(1));
    check("col_words1", 64'(words_loaded), 64'(1));
    @(negedge clk);
    check("col_resetn_run", 64'(core_resetn), 64'(1));

    // One-cycle reset while running, then a fresh load
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("rrun");
    @(negedge clk);
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h0BAD_F00D;
    img[2] = 32'hC001_D00D;
    send_image(3, 5, 8'h00);
    check("rrun_done",  64'(load_done),    64'(1));
    check("rrun_words", 64'(words_loaded), 64'(3));
    check("rrun_queue", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
